// File: rtl/background_model_ctrl.sv
// background_model_ctrl: frame tracker and bring-up sequencer (bypass warm-up, fast learn, run) for the background-model datapath.
// Define BGM_CTRL_STALL_FLUSH_EN to build the stall watchdog that drives force_ready.
module background_model_ctrl #(
    parameter int FRAME_LINES  = 480,
    parameter int CNT_W        = 16,
    parameter int STALL_CYCLES = 1024
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic [7:0]       cfg_bg_th,
    input  logic [7:0]       cfg_fd_th,
    input  logic [7:0]       cfg_alpha,
    input  logic [7:0]       cfg_alpha_fast,
    input  logic [CNT_W-1:0] cfg_warmup_frames,
    input  logic [CNT_W-1:0] cfg_learn_frames,
    input  logic             err_clear,
    input  logic             mon_tvalid,
    input  logic             mon_tready,
    input  logic             mon_tuser,
    input  logic             mon_tlast,
    input  logic             mon_out_tready,
    output logic             ce,
    output logic [7:0]       alpha,
    output logic [7:0]       bg_th,
    output logic [7:0]       fd_th,
    output logic             force_ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             sof_err
);
    localparam int LW = $clog2(FRAME_LINES + 1);
    localparam logic [LW-1:0] LAST = LW'(FRAME_LINES - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, LEARN, RUN} state_t;

    state_t st, st_n;
    logic [LW-1:0] line_cnt, lc_eff;
    logic [CNT_W-1:0] wc, wc_n, lc, lc_n, wc_inc, lc_inc;
    logic synced, beat, sof, le, fe;

    // an SOF restarts the line count before the same beat is judged as a line/frame end
    assign beat   = mon_tvalid & mon_tready;
    assign sof    = beat & mon_tuser;
    assign le     = beat & mon_tlast & (synced | sof);
    assign lc_eff = sof ? '0 : line_cnt;
    assign fe     = le & (lc_eff == LAST);
    assign wc_inc = wc + CNT_W'(1);
    assign lc_inc = lc + CNT_W'(1);
    assign state  = st;

    always_comb begin
        st_n = st;
        wc_n = wc;
        lc_n = lc;
        if (fe) begin
            if (st != IDLE && !enable)
                st_n = IDLE;
            else
                case (st)
                    IDLE: if (enable) begin
                        wc_n = '0;
                        lc_n = '0;
                        st_n = cfg_warmup_frames != '0 ? WARMUP : cfg_learn_frames != '0 ? LEARN : RUN;
                    end
                    WARMUP: begin
                        wc_n = wc_inc;
                        if (wc_inc == cfg_warmup_frames) begin
                            lc_n = '0;
                            st_n = cfg_learn_frames != '0 ? LEARN : RUN;
                        end
                    end
                    LEARN: begin
                        lc_n = lc_inc;
                        if (lc_inc == cfg_learn_frames)
                            st_n = RUN;
                    end
                    default: ;
                endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            st        <= IDLE;
            wc        <= '0;
            lc        <= '0;
            line_cnt  <= '0;
            synced    <= 1'b0;
            sof_err   <= 1'b0;
            frame_cnt <= '0;
            ce        <= 1'b0;
            alpha     <= '0;
            bg_th     <= '0;
            fd_th     <= '0;
        end else begin
            st       <= st_n;
            wc       <= wc_n;
            lc       <= lc_n;
            line_cnt <= fe ? '0 : le ? lc_eff + LW'(1) : lc_eff;
            if (sof)
                synced <= 1'b1;
            if (sof && line_cnt != '0)
                sof_err <= 1'b1;
            else if (err_clear)
                sof_err <= 1'b0;
            if (fe) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                bg_th     <= cfg_bg_th;
                fd_th     <= cfg_fd_th;
                ce        <= st_n == LEARN || st_n == RUN;
                alpha     <= st_n == LEARN ? cfg_alpha_fast : st_n == RUN ? cfg_alpha : '0;
            end
        end
    end

`ifdef BGM_CTRL_STALL_FLUSH_EN
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);

    logic [SW-1:0] stall_cnt;
    logic stall;

    assign stall = mon_tvalid & ~mon_out_tready;

    // flush holds until the frame boundary, then the watchdog rearms from zero
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_cnt   <= '0;
            force_ready <= 1'b0;
        end else if (fe | sof) begin
            stall_cnt   <= '0;
            force_ready <= 1'b0;
        end else if (force_ready | ~stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt == STALL_LAST) begin
            stall_cnt   <= '0;
            force_ready <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end
`else
    logic unused_stall;
    assign unused_stall = mon_out_tready ^ (STALL_CYCLES == 0);
    assign force_ready  = 1'b0;
`endif
endmodule

// File: tb/tb_background_model_ctrl.sv
// tb_background_model_ctrl: schedule table, hand sequences and randomized frames checked against a frame-level model.
module tb_background_model_ctrl;
    localparam int FL = 480;

    logic aclk = 0, areset = 1, enable = 0, err_clear = 0;
    logic mon_tvalid = 0, mon_tready = 0, mon_tuser = 0, mon_tlast = 0, mon_out_tready = 1;
    logic [7:0] cfg_bg_th = 0, cfg_fd_th = 0, cfg_alpha = 8'h3c, cfg_alpha_fast = 8'ha5;
    logic [15:0] cfg_warmup_frames = 0, cfg_learn_frames = 0;

    logic ce, force_ready, sof_err, ce_1, force_ready_1, sof_err_1;
    logic [7:0] alpha, bg_th, fd_th, alpha_1, bg_th_1, fd_th_1;
    logic [1:0] state, state_1;
    logic [15:0] frame_cnt, frame_cnt_1;

    background_model_ctrl dut (
        .aclk(aclk), .areset(areset), .enable(enable),
        .cfg_bg_th(cfg_bg_th), .cfg_fd_th(cfg_fd_th), .cfg_alpha(cfg_alpha), .cfg_alpha_fast(cfg_alpha_fast),
        .cfg_warmup_frames(cfg_warmup_frames), .cfg_learn_frames(cfg_learn_frames), .err_clear(err_clear),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .mon_out_tready(mon_out_tready), .ce(ce), .alpha(alpha), .bg_th(bg_th), .fd_th(fd_th),
        .force_ready(force_ready), .state(state), .frame_cnt(frame_cnt), .sof_err(sof_err)
    );

    background_model_ctrl #(.FRAME_LINES(1)) dut1 (
        .aclk(aclk), .areset(areset), .enable(enable),
        .cfg_bg_th(cfg_bg_th), .cfg_fd_th(cfg_fd_th), .cfg_alpha(cfg_alpha), .cfg_alpha_fast(cfg_alpha_fast),
        .cfg_warmup_frames(cfg_warmup_frames), .cfg_learn_frames(cfg_learn_frames), .err_clear(err_clear),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .mon_out_tready(mon_out_tready), .ce(ce_1), .alpha(alpha_1), .bg_th(bg_th_1), .fd_th(fd_th_1),
        .force_ready(force_ready_1), .state(state_1), .frame_cnt(frame_cnt_1), .sof_err(sof_err_1)
    );

    always #5 aclk = ~aclk;

    int checks = 0, failures = 0;

    bit m_synced, m_err, m_ce;
    int m_line, m_state, m_wl, m_ll;
    logic [15:0] m_frames;
    logic [7:0] m_alpha, m_bg, m_fd;

    typedef struct {
        logic [15:0] w;
        logic [15:0] l;
        logic [15:0] seq;
    } sched_t;
    sched_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_synced = 0; m_err = 0; m_ce = 0; m_line = 0; m_state = 0; m_wl = 0; m_ll = 0;
        m_frames = 0; m_alpha = 0; m_bg = 0; m_fd = 0;
    endfunction

    // frame-level model: remaining-frame budgets instead of up-counters
    function automatic void m_edge();
        bit beat, sof, fe, eset;
        if (areset) begin
            m_reset();
            return;
        end
        beat = mon_tvalid && mon_tready;
        sof = beat && mon_tuser;
        fe = 0;
        eset = 0;
        if (sof) begin
            eset = m_line != 0;
            m_line = 0;
            m_synced = 1;
        end
        if (beat && mon_tlast && m_synced) begin
            if (m_line == FL - 1) begin
                fe = 1;
                m_line = 0;
            end else m_line++;
        end
        if (eset) m_err = 1;
        else if (err_clear) m_err = 0;
        if (fe) begin
            m_frames++;
            m_bg = cfg_bg_th;
            m_fd = cfg_fd_th;
            if (m_state != 0 && !enable) m_state = 0;
            else if (m_state == 0 && enable) begin
                m_wl = int'(cfg_warmup_frames);
                m_ll = int'(cfg_learn_frames);
                m_state = m_wl != 0 ? 1 : m_ll != 0 ? 2 : 3;
            end else if (m_state == 1) begin
                m_wl--;
                if (m_wl == 0) m_state = m_ll != 0 ? 2 : 3;
            end else if (m_state == 2) begin
                m_ll--;
                if (m_ll == 0) m_state = 3;
            end
            m_ce = m_state >= 2;
            m_alpha = m_state == 2 ? cfg_alpha_fast : m_state == 3 ? cfg_alpha : 8'h0;
        end
    endfunction

    task automatic check_all();
        bit fr_bad;
        fr_bad = 0;
`ifndef BGM_CTRL_STALL_FLUSH_EN
        fr_bad = force_ready !== 1'b0;
`endif
        checks++;
        if (ce !== m_ce || alpha !== m_alpha || bg_th !== m_bg || fd_th !== m_fd || state !== 2'(m_state) ||
            frame_cnt !== m_frames || sof_err !== m_err || fr_bad) begin
            failures++;
            $display("FAIL outputs t=%0t actual ce=%0b alpha=%0h bg=%0h fd=%0h st=%0d fc=%0d err=%0b fr=%0b required ce=%0b alpha=%0h bg=%0h fd=%0h st=%0d fc=%0d err=%0b",
                     $time, ce, alpha, bg_th, fd_th, state, frame_cnt, sof_err, force_ready,
                     m_ce, m_alpha, m_bg, m_fd, m_state, m_frames, m_err);
        end
    endtask

    task automatic step(input logic v, input logic r, input logic u, input logic l);
        mon_tvalid = v;
        mon_tready = r;
        mon_tuser = u;
        mon_tlast = l;
        @(posedge aclk);
        m_edge();
        #1 check_all();
    endtask

    task automatic idle();
        logic v;
        v = 1'($urandom);
        step(v, v ? 1'b0 : 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send_lines(input int n, input bit sof, input int bpl, input int gap);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < bpl; b++) begin
                while (gap != 0 && $urandom_range(0, 99) < gap) idle();
                step(1, 1, sof && i == 0 && b == 0, b == bpl - 1);
            end
    endtask

    task automatic reset_dut();
        areset = 1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        areset = 0;
        step(0, 0, 0, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] sq;
        logic [1:0] es;
        int k;
        tbl[0] = '{16'd2, 16'd3, {2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3}};
        tbl[1] = '{16'd0, 16'd0, {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
        tbl[2] = '{16'd0, 16'd2, {2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
        tbl[3] = '{16'd1, 16'd0, {2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
        tbl[4] = '{16'd3, 16'd1, {2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3}};
        m_reset();
        reset_dut();
        chk("reset_state", state, 2'd0);
        chk("reset_frame_cnt", frame_cnt, 16'd0);
        chk("reset_ce", ce, 1'b0);
        chk("reset_alpha", alpha, 8'h0);

        // bring-up schedule table
        for (int r = 0; r < 5; r++) begin
            reset_dut();
            cfg_warmup_frames = tbl[r].w;
            cfg_learn_frames = tbl[r].l;
            enable = 1;
            sq = tbl[r].seq;
            for (int f = 0; f < 8; f++) begin
                send_lines(FL, 1, 1, 0);
                es = sq[15 - 2 * f -: 2];
                chk("sched_state", state, es);
                chk("sched_ce", ce, es >= 2);
                chk("sched_alpha", alpha, es == 3 ? cfg_alpha : es == 2 ? cfg_alpha_fast : 8'h0);
            end
        end

        // shadowed thresholds
        reset_dut();
        enable = 0;
        cfg_bg_th = 10;
        send_lines(FL, 1, 1, 0);
        chk("shadow_load", bg_th, 8'd10);
        send_lines(100, 1, 1, 0);
        cfg_bg_th = 50;
        send_lines(FL - 101, 0, 1, 0);
        chk("shadow_hold", bg_th, 8'd10);
        step(1, 1, 0, 1);
        chk("shadow_update", bg_th, 8'd50);

        // framing error, err_clear, set beats clear
        reset_dut();
        cfg_warmup_frames = 2;
        cfg_learn_frames = 3;
        enable = 1;
        send_lines(FL, 1, 1, 0);
        send_lines(200, 1, 1, 0);
        send_lines(1, 1, 1, 0);
        chk("sof_err_set", sof_err, 1'b1);
        chk("sof_err_frame_cnt", frame_cnt, 16'd1);
        chk("sof_err_state", state, 2'd1);
        send_lines(FL - 1, 0, 1, 0);
        chk("after_err_frame_cnt", frame_cnt, 16'd2);
        err_clear = 1;
        step(0, 0, 0, 0);
        err_clear = 0;
        chk("err_clear", sof_err, 1'b0);
        send_lines(3, 1, 1, 0);
        err_clear = 1;
        step(1, 1, 1, 0);
        err_clear = 0;
        chk("err_set_wins", sof_err, 1'b1);

        // enable drop takes effect only at frame end
        reset_dut();
        cfg_warmup_frames = 0;
        cfg_learn_frames = 0;
        enable = 1;
        send_lines(FL, 1, 1, 0);
        chk("zero_counts_state", state, 2'd3);
        chk("zero_counts_alpha", alpha, 8'h3c);
        enable = 0;
        send_lines(200, 1, 1, 0);
        chk("disable_mid_frame", state, 2'd3);
        send_lines(FL - 200, 0, 1, 0);
        chk("disable_state", state, 2'd0);
        chk("disable_ce", ce, 1'b0);

        // asynchronous reset mid-frame, resync only on SOF
        enable = 1;
        send_lines(FL, 1, 1, 0);
        send_lines(50, 1, 1, 0);
        #2 areset = 1;
        #1 m_reset();
        chk("async_reset_state", state, 2'd0);
        chk("async_reset_ce", ce, 1'b0);
        step(0, 0, 0, 0);
        areset = 0;
        send_lines(FL, 0, 1, 0);
        chk("unsynced_no_fe", frame_cnt, 16'd0);
        send_lines(FL, 1, 1, 0);
        chk("resync_frame_cnt", frame_cnt, 16'd1);
        chk("resync_no_err", sof_err, 1'b0);

        // single-line frames: SOF and tlast on one beat
        reset_dut();
        enable = 1;
        step(1, 1, 1, 1);
        chk("fl1_sof_fe", frame_cnt_1, 16'd1);
        chk("fl1_state", state_1, 2'd3);
        chk("fl1_ce", ce_1, 1'b1);
        step(1, 1, 0, 1);
        chk("fl1_line_fe", frame_cnt_1, 16'd2);
        step(1, 1, 1, 0);
        chk("fl1_no_err", sof_err_1, 1'b0);

`ifdef BGM_CTRL_STALL_FLUSH_EN
        reset_dut();
        send_lines(5, 1, 1, 0);
        mon_out_tready = 0;
        for (int i = 0; i < 1023; i++) step(1, 0, 0, 0);
        chk("stall_not_yet", force_ready, 1'b0);
        step(1, 0, 0, 0);
        chk("stall_flush", force_ready, 1'b1);
        send_lines(FL - 6, 0, 1, 0);
        chk("flush_hold", force_ready, 1'b1);
        step(1, 1, 0, 1);
        chk("flush_drop", force_ready, 1'b0);
        mon_out_tready = 1;
`endif

        // randomized frames against the model
        for (int s = 0; s < 4; s++) begin
            reset_dut();
            cfg_warmup_frames = 16'($urandom_range(0, 2));
            cfg_learn_frames = 16'($urandom_range(0, 2));
            cfg_alpha = 8'($urandom);
            cfg_alpha_fast = 8'($urandom);
            for (int f = 0; f < 6; f++) begin
                enable = $urandom_range(0, 5) != 0;
                err_clear = $urandom_range(0, 3) == 0;
                mon_out_tready = 1'($urandom);
                cfg_fd_th = 8'($urandom);
                if ($urandom_range(0, 4) == 0) send_lines($urandom_range(1, 50), 1, 1, 20);
                k = $urandom_range(1, FL - 1);
                send_lines(k, 1, 1, 20);
                cfg_bg_th = 8'($urandom);
                send_lines(FL - k, 0, $urandom_range(1, 2), 20);
            end
        end
        err_clear = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
